// File: rtl/instr_fetch_ctrl.sv
// Instruction fetch sequencer: owns the fetch PC, prefetches {pc, instr} pairs into a small FIFO
// and hands them to decode over valid/ready. Optional macro: FETCH_MISALIGN_CHK_EN.
module instr_fetch_ctrl #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  input  logic        halt,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic [31:0] out_pc,
  output logic        misalign_err
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  typedef enum logic [1:0] {S_BOOT, S_RUN, S_HALT} state_e;

  state_e        state_q, state_d;
  logic [31:0]   fetch_pc_q, fetch_pc_d;
  logic [PW-1:0] rd_q, rd_d, wr_q, wr_d;
  logic [CW-1:0] count_q, count_d;
  logic          out_valid_q, out_valid_d;
  logic [31:0]   out_pc_q, out_pc_d;
  logic [31:0]   out_instr_q, out_instr_d;
  logic [31:0]   pc_mem_q    [DEPTH];
  logic [31:0]   instr_mem_q [DEPTH];
  logic          pop, push;

`ifdef FETCH_MISALIGN_CHK_EN
  logic misalign;
  logic misalign_err_q;
  assign misalign     = redirect_valid && (redirect_pc[1:0] != 2'b00);
  assign misalign_err = misalign_err_q;
`else
  assign misalign_err = 1'b0;
`endif

  assign imem_addr = fetch_pc_q;
  assign out_valid = out_valid_q;
  assign out_pc    = out_pc_q;
  assign out_instr = out_instr_q;

  // A full FIFO can still accept a fetch when decode drains the head in the same cycle.
  always_comb begin
    pop  = (count_q != '0) && out_ready;
    push = (state_q == S_RUN) && !halt && !redirect_valid && ((count_q != FULL_CNT) || pop);
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_BOOT:  state_d = S_RUN;
      S_RUN:   if (halt) state_d = S_HALT;
      S_HALT:  if (!halt) state_d = S_RUN;
      default: state_d = S_BOOT;
    endcase
`ifdef FETCH_MISALIGN_CHK_EN
    if (misalign) state_d = S_HALT;
`endif
  end

  always_comb begin
    fetch_pc_d  = fetch_pc_q;
    rd_d        = rd_q;
    wr_d        = wr_q;
    count_d     = count_q;
    out_valid_d = 1'b0;
    out_pc_d    = out_pc_q;
    out_instr_d = out_instr_q;
    if (redirect_valid) begin
      fetch_pc_d = redirect_pc & 32'hFFFF_FFFC;
      rd_d       = '0;
      wr_d       = '0;
      count_d    = '0;
    end else begin
      if (pop) rd_d = rd_q + PW'(1);
      if (push) begin
        wr_d       = wr_q + PW'(1);
        fetch_pc_d = fetch_pc_q + 32'd4;
      end
      count_d     = count_q + CW'(push) - CW'(pop);
      out_valid_d = (count_d != '0);
      // The new head is the word being fetched right now only when it is the sole entry left.
      if (count_d != '0) begin
        if (push && (rd_d == wr_q)) begin
          out_pc_d    = fetch_pc_q;
          out_instr_d = imem_rdata;
        end else begin
          out_pc_d    = pc_mem_q[rd_d];
          out_instr_d = instr_mem_q[rd_d];
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_BOOT;
      fetch_pc_q  <= RESET_PC;
      rd_q        <= '0;
      wr_q        <= '0;
      count_q     <= '0;
      out_valid_q <= 1'b0;
      out_pc_q    <= '0;
      out_instr_q <= '0;
    end else begin
      state_q     <= state_d;
      fetch_pc_q  <= fetch_pc_d;
      rd_q        <= rd_d;
      wr_q        <= wr_d;
      count_q     <= count_d;
      out_valid_q <= out_valid_d;
      out_pc_q    <= out_pc_d;
      out_instr_q <= out_instr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      pc_mem_q[wr_q]    <= fetch_pc_q;
      instr_mem_q[wr_q] <= imem_rdata;
    end
  end

`ifdef FETCH_MISALIGN_CHK_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) misalign_err_q <= 1'b0;
    else        misalign_err_q <= misalign;
  end
`endif

endmodule

// File: tb/tb_instr_fetch_ctrl.sv
// Bench for instr_fetch_ctrl: queue-based reference model checked every cycle, plus directed
// literal expectations. Instruction memory returns word index: mem[k] = k.
module tb_instr_fetch_ctrl;
  localparam int DEPTH = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] imem_addr, imem_rdata;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = 32'h0;
  logic        halt = 1'b0;
  logic        out_valid, out_ready = 1'b1;
  logic [31:0] out_instr, out_pc;
  logic        misalign_err;

  int total = 0;
  int bad   = 0;
  bit chk_en = 1'b0;

  instr_fetch_ctrl #(.RESET_PC(32'h0), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .halt(halt),
    .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr), .out_pc(out_pc),
    .misalign_err(misalign_err)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] memw(input logic [31:0] a);
    return {2'b00, a[31:2]};
  endfunction

  assign imem_rdata = memw(imem_addr);

  typedef struct packed { logic [31:0] pc; logic [31:0] ins; } ent_t;
  ent_t        q[$];
  logic [31:0] m_pc = 32'h0;
  bit          m_boot = 1'b1;
  bit          m_halted = 1'b0;
  bit          m_ov = 1'b0;
  logic [31:0] m_opc = 32'h0;
  logic [31:0] m_oin = 32'h0;
  bit          m_mis = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Reference model: the FIFO is a plain queue, decode takes the front, fetch appends.
  initial begin
    bit   pop_m, fetch_m;
    ent_t e;
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        q.delete();
        m_pc = 32'h0; m_boot = 1'b1; m_halted = 1'b0;
        m_ov = 1'b0; m_opc = 32'h0; m_oin = 32'h0; m_mis = 1'b0;
      end else begin
        pop_m   = (q.size() != 0) && out_ready;
        fetch_m = !redirect_valid && !m_boot && !m_halted && !halt && ((q.size() < DEPTH) || pop_m);
        m_mis   = 1'b0;
        if (redirect_valid) begin
          q.delete();
          m_pc = redirect_pc & ~32'd3;
`ifdef FETCH_MISALIGN_CHK_EN
          m_mis = (redirect_pc % 4) != 0;
`endif
        end else begin
          if (pop_m) void'(q.pop_front());
          if (fetch_m) begin
            e.pc = m_pc; e.ins = memw(m_pc);
            q.push_back(e);
            m_pc = m_pc + 32'd4;
          end
        end
        if (m_boot) begin m_boot = 1'b0; m_halted = 1'b0; end
        else m_halted = halt;
        if (m_mis) m_halted = 1'b1;
        if (q.size() != 0) begin m_ov = 1'b1; m_opc = q[0].pc; m_oin = q[0].ins; end
        else m_ov = 1'b0;
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (chk_en && rst_n) begin
        chk("cyc_out_valid", 32'(out_valid), 32'(m_ov));
        chk("cyc_out_pc", out_pc, m_opc);
        chk("cyc_out_instr", out_instr, m_oin);
        chk("cyc_imem_addr", imem_addr, m_pc);
        chk("cyc_misalign", 32'(misalign_err), 32'(m_mis));
      end
    end
  end

  task automatic step(input bit rdy, input bit hlt, input bit rv, input logic [31:0] rpc);
    out_ready = rdy; halt = hlt; redirect_valid = rv; redirect_pc = rpc;
    @(posedge clk); #2;
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #2;
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_pc", out_pc, 32'h0);
    chk("rst_instr", out_instr, 32'h0);
    chk("rst_addr", imem_addr, 32'h0);
    chk("rst_mis", 32'(misalign_err), 32'd0);
    rst_n = 1'b1; chk_en = 1'b1;

    // Streaming from reset
    step(1, 0, 0, 0);
    chk("boot_novalid", 32'(out_valid), 32'd0);
    chk("boot_addr", imem_addr, 32'h0);
    step(1, 0, 0, 0);
    chk("first_valid", 32'(out_valid), 32'd1);
    chk("first_pc", out_pc, 32'h0);
    chk("first_addr", imem_addr, 32'h4);
    step(1, 0, 0, 0);
    chk("second_pc", out_pc, 32'h4);
    chk("second_instr", out_instr, 32'h1);
    repeat (3) step(1, 0, 0, 0);

    // Backpressure
    repeat (5) step(0, 0, 0, 0);
    chk("full_addr", imem_addr, 32'd24);
    chk("full_head", out_pc, 32'd16);
    step(1, 0, 0, 0);
    chk("drain_pc0", out_pc, 32'd20);
    step(1, 0, 0, 0);
    chk("drain_pc1", out_pc, 32'd24);
    chk("drain_addr", imem_addr, 32'd32);

    // Redirect while full
    step(0, 0, 1, 32'h20);
    chk("redir_novalid", 32'(out_valid), 32'd0);
    chk("redir_addr", imem_addr, 32'h20);
    chk("redir_hold_pc", out_pc, 32'd24);
    step(1, 0, 0, 0);
    chk("redir_pc", out_pc, 32'h20);
    chk("redir_instr", out_instr, 32'd8);
    step(1, 0, 0, 0);
    chk("redir_pc2", out_pc, 32'h24);

    // Halt drains queued entries
    step(0, 0, 0, 0);
    step(1, 1, 0, 0);
    step(1, 1, 0, 0);
    chk("halt_empty", 32'(out_valid), 32'd0);
    chk("halt_last_pc", out_pc, 32'h28);
    chk("halt_addr", imem_addr, 32'h2C);
    step(1, 1, 0, 0);
    chk("halt_addr2", imem_addr, 32'h2C);
    step(1, 0, 0, 0);
    chk("unhalt_gap", 32'(out_valid), 32'd0);
    step(1, 0, 0, 0);
    chk("resume_pc", out_pc, 32'h2C);
    chk("resume_instr", out_instr, 32'hB);

    // Redirect while halted keeps halting
    step(1, 1, 0, 0);
    step(1, 1, 1, 32'h40);
    step(1, 1, 0, 0);
    chk("hredir_addr", imem_addr, 32'h40);
    chk("hredir_novalid", 32'(out_valid), 32'd0);
    step(1, 0, 0, 0);
    step(1, 0, 0, 0);
    chk("hredir_pc", out_pc, 32'h40);
    chk("hredir_instr", out_instr, 32'h10);

    // PC wrap at the top of the address space
    step(1, 0, 1, 32'hFFFF_FFF8);
    repeat (3) step(1, 0, 0, 0);
    chk("wrap_pc", out_pc, 32'h0);
    chk("wrap_addr", imem_addr, 32'h4);

    // Asynchronous reset mid-stream
    step(1, 0, 0, 0);
    rst_n = 1'b0;
    #1;
    chk("arst_valid", 32'(out_valid), 32'd0);
    chk("arst_pc", out_pc, 32'h0);
    chk("arst_instr", out_instr, 32'h0);
    chk("arst_addr", imem_addr, 32'h0);
    @(posedge clk); #2;
    rst_n = 1'b1;
    step(1, 0, 0, 0);
    step(1, 0, 0, 0);
    chk("arst_refetch_valid", 32'(out_valid), 32'd1);
    chk("arst_refetch_pc", out_pc, 32'h0);

    // Misaligned redirect
    step(1, 0, 1, 32'h22);
    chk("mis_addr", imem_addr, 32'h20);
    chk("mis_novalid", 32'(out_valid), 32'd0);
`ifdef FETCH_MISALIGN_CHK_EN
    chk("mis_pulse", 32'(misalign_err), 32'd1);
    step(1, 0, 0, 0);
    chk("mis_pulse_end", 32'(misalign_err), 32'd0);
    chk("mis_halted", 32'(out_valid), 32'd0);
    step(1, 0, 0, 0);
    chk("mis_resume_pc", out_pc, 32'h20);
`else
    chk("mis_tied", 32'(misalign_err), 32'd0);
    step(1, 0, 0, 0);
    chk("mis_resume_pc", out_pc, 32'h20);
    chk("mis_resume_instr", out_instr, 32'd8);
`endif
    repeat (3) step(1, 0, 0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
